// File: rtl/dds_wb_master.sv
// Wishbone classic initiator for the DDS register port: queues register commands,
// runs one single-beat cycle at a time and returns one response per command.
module dds_wb_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic                  cmd_lock_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_dat_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_dat_o,
    output logic                  rsp_err_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic                  wb_lock_o,
    output logic [ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_ack_i
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef struct packed {
        logic                  we;
        logic                  lock;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] dat;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    cmd_t          mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;
    cmd_t          head;

    state_t                state, state_nxt;
    logic [TW-1:0]         tmo_cnt, tmo_nxt;
    logic                  cur_lock, cur_lock_nxt;
    logic                  cyc_nxt, stb_nxt, we_nxt, lock_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] dat_nxt;
    logic                  rsp_valid_nxt, rsp_err_nxt;
    logic [DATA_WIDTH-1:0] rsp_dat_nxt;
    logic                  tmo_hit;

    assign cmd_ready_o = (count != CW'(FIFO_DEPTH));
    assign push        = cmd_valid_i && cmd_ready_o;
    assign pop         = (state == IDLE) && (count != '0);
    assign head        = mem[rd_ptr];
    assign tmo_hit     = (tmo_cnt == TW'(TIMEOUT - 1));

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge wb_clk_i) begin
        if (push)
            mem[wr_ptr] <= {cmd_we_i, cmd_lock_i, cmd_addr_i, cmd_dat_i};
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // State register plus all registered bus/response outputs.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            cur_lock    <= 1'b0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_lock_o   <= 1'b0;
            wb_addr_o   <= '0;
            wb_dat_o    <= '0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            state       <= state_nxt;
            tmo_cnt     <= tmo_nxt;
            cur_lock    <= cur_lock_nxt;
            wb_cyc_o    <= cyc_nxt;
            wb_stb_o    <= stb_nxt;
            wb_we_o     <= we_nxt;
            wb_lock_o   <= lock_nxt;
            wb_addr_o   <= addr_nxt;
            wb_dat_o    <= dat_nxt;
            rsp_valid_o <= rsp_valid_nxt;
            rsp_dat_o   <= rsp_dat_nxt;
            rsp_err_o   <= rsp_err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop) state_nxt = REQ;
            REQ:     if (wb_ack_i || tmo_hit) state_nxt = RSP;
            RSP:     if (rsp_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cyc_nxt       = wb_cyc_o;
        stb_nxt       = wb_stb_o;
        we_nxt        = wb_we_o;
        lock_nxt      = wb_lock_o;
        addr_nxt      = wb_addr_o;
        dat_nxt       = wb_dat_o;
        cur_lock_nxt  = cur_lock;
        tmo_nxt       = tmo_cnt;
        rsp_valid_nxt = rsp_valid_o;
        rsp_dat_nxt   = rsp_dat_o;
        rsp_err_nxt   = rsp_err_o;
        case (state)
            IDLE: begin
                if (pop) begin
                    cyc_nxt      = 1'b1;
                    stb_nxt      = 1'b1;
                    we_nxt       = head.we;
                    addr_nxt     = head.addr;
                    dat_nxt      = head.dat;
                    cur_lock_nxt = head.lock;
                    // An already-held lock stays asserted until this command's ack.
                    lock_nxt     = head.lock | wb_lock_o;
                    tmo_nxt      = '0;
                end
            end
            REQ: begin
                if (wb_ack_i) begin
                    stb_nxt       = 1'b0;
                    cyc_nxt       = cur_lock;
                    lock_nxt      = cur_lock;
                    rsp_valid_nxt = 1'b1;
                    rsp_dat_nxt   = wb_we_o ? '0 : wb_dat_i;
                    rsp_err_nxt   = 1'b0;
                end else if (tmo_hit) begin
                    cyc_nxt       = 1'b0;
                    stb_nxt       = 1'b0;
                    lock_nxt      = 1'b0;
                    cur_lock_nxt  = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_dat_nxt   = '0;
                    rsp_err_nxt   = 1'b1;
                end else begin
                    tmo_nxt = tmo_cnt + 1'b1;
                end
            end
            RSP: begin
                if (rsp_ready_i) rsp_valid_nxt = 1'b0;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dds_wb_master.sv
// Scoreboard bench: each pushed command queues its expected bus beat and response;
// a slave model and a response consumer pop and compare as the DUT produces them.
module tb_dds_wb_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid_i = 1'b0, cmd_we_i = 1'b0, cmd_lock_i = 1'b0;
    logic [4:0]  cmd_addr_i = '0;
    logic [31:0] cmd_dat_i = '0;
    logic        cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_ready_i = 1'b0;
    logic [31:0] rsp_dat_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_lock_o, wb_ack_i = 1'b0;
    logic [4:0]  wb_addr_o;
    logic [31:0] wb_dat_o, wb_dat_i = '0;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] dat;
        int          dly;
    } txn_t;
    typedef struct {
        logic [31:0] dat;
        logic        err;
    } rsp_t;

    txn_t iss_q[$];
    rsp_t exp_q[$];
    txn_t cur;
    int   n_chk = 0, n_err = 0, n_rsp = 0, wait_cnt = 0;
    bit   in_txn = 0;

    always #5 clk = ~clk;

    dds_wb_master #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FIFO_DEPTH(4), .TIMEOUT(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_lock_i(cmd_lock_i), .cmd_addr_i(cmd_addr_i), .cmd_dat_i(cmd_dat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
        .rsp_err_o(rsp_err_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_lock_o(wb_lock_o), .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [4:0] a);
        return 32'hDEAD_BEEE + {27'd0, a};
    endfunction

    // dly < 0: slave never acks; otherwise ack on the (dly+1)-th strobe cycle.
    task automatic push_cmd(input logic we, input logic lk, input logic [4:0] a,
                            input logic [31:0] d, input int dly);
        txn_t t;
        rsp_t r;
        int   n = 0;
        cmd_valid_i = 1'b1; cmd_we_i = we; cmd_lock_i = lk; cmd_addr_i = a; cmd_dat_i = d;
        while (!cmd_ready_o && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) chk("push_wait", 32'(cmd_ready_o), 32'd1);
        t.we = we; t.addr = a; t.dat = d; t.dly = dly;
        iss_q.push_back(t);
        r.err = (dly < 0);
        r.dat = (dly < 0 || we) ? 32'd0 : rd_model(a);
        exp_q.push_back(r);
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int n = 0;
        while (n_rsp < target && n < 200) begin @(posedge clk); #2; n++; end
        chk("rsp_cnt", 32'(n_rsp), 32'(target));
    endtask

    // Slave model: checks each beat against the issue queue and keeps it stable.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            wb_ack_i = 1'b0; in_txn = 0;
        end else if (wb_cyc_o && wb_stb_o) begin
            if (!in_txn) begin
                in_txn = 1; wait_cnt = 0;
                if (iss_q.size() == 0) begin
                    chk("iss_extra", 32'(wb_addr_o), 32'h0);
                    cur.we = wb_we_o; cur.addr = wb_addr_o; cur.dat = wb_dat_o; cur.dly = 0;
                end else begin
                    cur = iss_q.pop_front();
                end
                chk("beat_we", 32'(wb_we_o), 32'(cur.we));
            end
            chk("beat_addr", 32'(wb_addr_o), 32'(cur.addr));
            if (cur.we) chk("beat_dat", wb_dat_o, cur.dat);
            if (cur.dly >= 0 && wait_cnt == cur.dly) begin
                wb_ack_i = 1'b1; wb_dat_i = rd_model(wb_addr_o);
            end else begin
                wb_ack_i = 1'b0;
            end
            wait_cnt++;
        end else begin
            wb_ack_i = 1'b0; in_txn = 0;
        end
    end

    // Response consumer: one scoreboard pop per handshake.
    initial forever begin
        @(negedge clk);
        if (!rst && rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("rsp_extra", 32'(rsp_valid_o), 32'd0);
            end else begin
                rsp_t r;
                r = exp_q.pop_front();
                chk("rsp_dat", rsp_dat_o, r.dat);
                chk("rsp_err", 32'(rsp_err_o), 32'(r.err));
            end
            n_rsp++;
        end
    end

    initial begin
        int cnt, rises, gap, bad, n;
        bit prev;
        repeat (3) @(posedge clk); #1;
        chk("rst_cyc", 32'(wb_cyc_o), 0);
        chk("rst_stb", 32'(wb_stb_o), 0);
        chk("rst_lock", 32'(wb_lock_o), 0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 0);
        chk("rst_rdy", 32'(cmd_ready_o), 1);
        rst = 1'b0; rsp_ready_i = 1'b1;
        @(posedge clk); #1;

        // Write with 2-cycle wait; checks issue latency.
        push_cmd(1'b1, 1'b0, 5'd3, 32'h0001_0000, 2);
        @(negedge clk); chk("lat_pre_stb", 32'(wb_stb_o), 0);
        @(negedge clk); chk("lat_stb", 32'(wb_stb_o), 1); chk("lat_cyc", 32'(wb_cyc_o), 1);
        wait_rsp(1);

        // Read held under response backpressure.
        rsp_ready_i = 1'b0;
        push_cmd(1'b0, 1'b0, 5'd1, 32'h0, 0);
        n = 0;
        while (!rsp_valid_o && n < 50) begin @(posedge clk); #1; n++; end
        chk("rd_valid", 32'(rsp_valid_o), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rd_hold_dat", rsp_dat_o, 32'hDEAD_BEEF);
            chk("rd_hold_stb", 32'(wb_stb_o), 0);
        end
        @(posedge clk); #1; rsp_ready_i = 1'b1;
        wait_rsp(2);

        // Timeout on an unacked read, then a queued write completes normally.
        push_cmd(1'b0, 1'b0, 5'd6, 32'h0, -1);
        push_cmd(1'b1, 1'b0, 5'd8, 32'h1234_5678, 1);
        cnt = 0; n = 0;
        while (n < 100) begin
            @(negedge clk); n++;
            if (rsp_valid_o) break;
            if (wb_stb_o) cnt++;
        end
        chk("tmo_cycles", 32'(cnt), 32'd16);
        chk("tmo_cyc", 32'(wb_cyc_o), 0);
        chk("tmo_err", 32'(rsp_err_o), 1);
        wait_rsp(4);

        // Backpressure: 1 in flight + 4 queued, 6th refused.
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) push_cmd(1'b0, 1'b0, 5'(10 + i), 32'h0, 0);
        cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 5'd20;
        for (int i = 0; i < 3; i++) begin
            chk("bp_full", 32'(cmd_ready_o), 0);
            @(posedge clk); #1;
        end
        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        wait_rsp(9);
        chk("bp_rdy_after", 32'(cmd_ready_o), 1);

        // Locked pair: cyc/lock stay high across both, strobe gap between.
        push_cmd(1'b1, 1'b1, 5'd2, 32'hA5A5_0002, 0);
        push_cmd(1'b1, 1'b0, 5'd4, 32'h5A5A_0004, 1);
        rises = 1; prev = 1; gap = 0; bad = 0; n = 0;
        while (n < 50) begin
            @(negedge clk); n++;
            if (!wb_cyc_o) break;
            if (!wb_lock_o) bad++;
            if (!wb_stb_o) gap++;
            if (wb_stb_o && !prev) rises++;
            prev = wb_stb_o;
        end
        chk("lk_beats", 32'(rises), 32'd2);
        chk("lk_lock_low", 32'(bad), 32'd0);
        chk("lk_gap", 32'(gap != 0), 32'd1);
        chk("lk_drop", 32'(wb_lock_o), 0);
        wait_rsp(11);

        // Async reset in the middle of an unacked write.
        push_cmd(1'b1, 1'b0, 5'd7, 32'hCAFE_F00D, -1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_cyc", 32'(wb_cyc_o), 0);
        chk("mid_rst_stb", 32'(wb_stb_o), 0);
        chk("mid_rst_we", 32'(wb_we_o), 0);
        chk("mid_rst_addr", 32'(wb_addr_o), 0);
        chk("mid_rst_dat", wb_dat_o, 0);
        chk("mid_rst_rsp", 32'(rsp_valid_o), 0);
        chk("mid_rst_rdy", 32'(cmd_ready_o), 1);
        iss_q.delete(); exp_q.delete();
        @(posedge clk); #1; rst = 1'b0;
        push_cmd(1'b0, 1'b0, 5'd5, 32'h0, 0);
        wait_rsp(12);
        chk("end_iss_q", 32'(iss_q.size()), 0);
        chk("end_exp_q", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/dds_wb_master.md
Name: dds_wb_master

Overview:
- Wishbone initiator that drives the DDS core's register interface: tuning, gain, offset, source, enable and user-memory writes, plus readback.
- Accepts a stream of register commands through a small command FIFO and issues single Wishbone classic cycles.
- Returns one response per command, with a bus-timeout error.
- Sits between a host/sequencer (sweep controller, UART bridge) and the DDS slave port.

Parameters:
- DATA_WIDTH, 32, Wishbone data width.
- ADDR_WIDTH, 5, Wishbone address width.
- FIFO_DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- TIMEOUT, 16, cycles in REQ without wb_ack_i before aborting; minimum 2.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  FIFO can accept a command.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_lock_i  in  1  keep the bus locked into the next command.
- cmd_addr_i  in  ADDR_WIDTH  register address.
- cmd_dat_i  in  DATA_WIDTH  write data (ignored for reads).
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  consumer takes the response.
- rsp_dat_o  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err_o  out  1  transaction timed out.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  strobe.
- wb_we_o  out  1  write enable.
- wb_lock_o  out  1  bus lock.
- wb_addr_o  out  ADDR_WIDTH  address.
- wb_dat_o  out  DATA_WIDTH  write data.
- wb_dat_i  in  DATA_WIDTH  read data.
- wb_ack_i  in  1  slave acknowledge.

Behaviour:
- Reset, async assert, sync-released by the clock:
  - All outputs 0 except cmd_ready_o = 1.
  - FIFO empty, state IDLE, timeout counter 0.
  - Reset mid-cycle drops wb_cyc_o/wb_stb_o/wb_lock_o immediately and discards any pending response.
- Command FIFO:
  - Push when cmd_valid_i && cmd_ready_o.
  - cmd_ready_o = (count != FIFO_DEPTH), derived from the registered count.
  - No fall-through: a command pushed on edge k is poppable from edge k+1.
  - Simultaneous push and pop: count unchanged, pointers both advance.
  - Pointers wrap modulo FIFO_DEPTH.
- All Wishbone and response outputs are registered.
- FSM states: IDLE, REQ, RSP.
  - IDLE: if FIFO non-empty, pop on the edge and load wb_we_o/wb_addr_o/wb_dat_o/wb_lock_o from the entry. Drive wb_cyc_o = wb_stb_o = 1 and go to REQ. Timeout counter clears to 0.
  - REQ: wb_ack_i sampled high on edge m:
    - wb_stb_o = 0 from edge m.
    - rsp_dat_o = wb_dat_i for reads, 0 for writes; rsp_err_o = 0; rsp_valid_o = 1.
    - Go to RSP.
    - wb_cyc_o stays 1 only if the current lock bit = 1, else 0.
  - REQ timeout: the counter increments each REQ cycle without ack. When it reaches TIMEOUT-1 with no ack:
    - wb_cyc_o = wb_stb_o = wb_lock_o = 0.
    - rsp_err_o = 1, rsp_dat_o = 0, rsp_valid_o = 1; go to RSP.
    - A timeout always releases the lock.
  - Ack on the same cycle as the timeout limit counts as ack (success).
  - RSP: hold rsp_* stable until rsp_ready_i. On the handshake edge h, clear rsp_valid_o and go to IDLE. The next wb_stb_o rises at the earliest on edge h+1.
  - Only one outstanding transaction; commands keep queuing during REQ/RSP.
- Lock:
  - While locked (last completed command had lock = 1 and no timeout), wb_cyc_o and wb_lock_o stay high through RSP and IDLE, even with the FIFO empty.
  - The lock ends when a command with lock = 0 is acked: wb_cyc_o and wb_lock_o drop on that ack edge.
- Latency:
  - Accept on edge k gives stb from edge k+1 (FIFO empty, IDLE).
  - Single-cycle slave ack gives rsp_valid_o from edge k+2.
- wb_dat_o and wb_addr_o are held stable for the whole REQ.

Test Plan:
- Write: push we=1 addr=3 dat=0x0001_0000, slave acks after 2 cycles. Expect wb_cyc_o/wb_stb_o/wb_we_o = 1 with addr 3 and that data until ack, then rsp_valid_o = 1, rsp_dat_o = 0, rsp_err_o = 0.
- Read: push we=0 addr=1, slave returns 0xDEAD_BEEF with ack. Expect rsp_dat_o = 0xDEAD_BEEF held while rsp_ready_i = 0 for 5 cycles; wb_stb_o low during that time.
- Timeout: push a read, never ack. Expect stb/cyc drop after TIMEOUT = 16 REQ cycles, rsp_err_o = 1, rsp_dat_o = 0. The next queued command is then issued normally.
- Backpressure:
  - Hold rsp_ready_i = 0 and push 6 commands.
  - Expect 1 in flight plus 4 queued, then cmd_ready_o = 0 and the 6th not accepted.
  - Release rsp_ready_i: all 5 complete in push order with addresses intact.
- Lock: push {lock=1, addr=2} and {lock=0, addr=4}. Expect wb_cyc_o and wb_lock_o continuously high across both transactions, dropping on the second ack; wb_stb_o low between them.
- Reset mid-REQ: assert wb_rst_i during an unacked write. Expect all wb_* outputs 0 asynchronously, cmd_ready_o = 1, rsp_valid_o = 0, and a subsequent command working normally.
